// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode enumeration for the ALU and its shifter.
package alu_pkg;

  typedef enum logic [3:0] {
    LSL  = 4'b0000,
    LSR  = 4'b0001,
    ASR  = 4'b0010,
    NOT  = 4'b0011,
    AND  = 4'b0100,
    OR   = 4'b0101,
    XOR  = 4'b0110,
    ADD  = 4'b0111,
    SUB  = 4'b1000,
    SBC  = 4'b1001,
    INC  = 4'b1010,
    DEC  = 4'b1011,
    NAND = 4'b1100,
    NOR  = 4'b1101,
    XNOR = 4'b1110,
    ROL  = 4'b1111
  } opcode_t;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational LSL / LSR / ASR / ROL with carry-out.
//   op    in  opcode (only the four shift/rotate codes are meaningful)
//   a     in  value to shift
//   b     in  unsigned shift amount (rotate amount taken modulo WIDTH)
//   y     out shifted result ('0 for non-shift opcodes)
//   cout  out last bit shifted out (LSL/LSR/ASR), y[0] for ROL
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  logic                   big;
  logic [WIDTH-1:0]       amt;
  logic [2*WIDTH-1:0]     rot;

  assign big = (b >= WIDTH_V);
  assign amt = b % WIDTH_V;

  // A spare bit appended on the exit side of each shift catches the
  // last bit shifted out, and is naturally 0 when b == 0.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    y    = '0;
    cout = 1'b0;
    rot  = '0;
    case (op)
      LSL: begin
        if (!big) {cout, y} = {1'b0, a} << b;
      end
      LSR: begin
        if (!big) {y, cout} = {a, 1'b0} >> b;
      end
      // Sign fill already yields all-sign y and cout=a[WIDTH-1] for b >= WIDTH.
      ASR: {y, cout} = $signed({a, 1'b0}) >>> b;
      ROL: begin
        rot  = {a, a} << amt;
        y    = rot[2*WIDTH-1:WIDTH];
        cout = rot[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: combinational ALU with a registered status-flag copy.
//   opcode    in  operation select (see alu_pkg::opcode_t)
//   a, b      in  operands; b is the shift/rotate amount for shift ops
//   cin       in  carry in for ADD and SBC
//   y         out result
//   cout      out carry out (no-borrow for SUB/SBC) or last bit shifted out
//   overflow  out signed overflow for ADD/SUB/SBC/INC/DEC, else 0
//   negative  out y[WIDTH-1]
//   zero      out y == 0
//   flags_q   out {negative, zero, cout, overflow} captured each clk edge
//   clk, rst  in  clock and asynchronous active-high reset (flags_q only)
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic [3:0]       flags_q,
  input  logic             clk,
  input  logic             rst
);

  opcode_t          op;
  logic [WIDTH-1:0] sh_y;
  logic             sh_cout;

  logic             arith;
  logic [WIDTH-1:0] opb;    // effective second adder operand
  logic             carry;  // effective adder carry in
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  assign op = opcode_t'(opcode);

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .op   (op),
    .a    (a),
    .b    (b),
    .y    (sh_y),
    .cout (sh_cout)
  );

  // All arithmetic ops share one WIDTH+1 bit adder: a + opb + carry.
  always_comb begin
    arith = 1'b0;
    opb   = '0;
    carry = 1'b0;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    case (op)
      LSL, LSR, ASR, ROL: begin
        res = sh_y;
        c   = sh_cout;
      end
      NOT:  res = ~a;
      AND:  res = a & b;
      OR:   res = a | b;
      XOR:  res = a ^ b;
      NAND: res = ~(a & b);
      NOR:  res = ~(a | b);
      XNOR: res = ~(a ^ b);
      ADD: begin arith = 1'b1; opb = b;  carry = cin;  end
      SUB: begin arith = 1'b1; opb = ~b; carry = 1'b1; end
      SBC: begin arith = 1'b1; opb = ~b; carry = cin;  end
      INC: begin arith = 1'b1; opb = '0; carry = 1'b1; end
      DEC: begin arith = 1'b1; opb = '1; carry = 1'b0; end
      default: ;
    endcase

    sum = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, carry};
    if (arith) begin
      res = sum[WIDTH-1:0];
      c   = sum[WIDTH];
      // Overflow: operands agree in sign but the result does not.
      v   = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

  assign y        = res;
  assign cout     = c;
  assign overflow = v;
  assign negative = res[WIDTH-1];
  assign zero     = (res == '0);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) flags_q <= '0;
    else     flags_q <= {negative, zero, cout, overflow};
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table, randomized model comparison, and reset
// sequences for the alu block (WIDTH = 4).
module tb_alu;
  import alu_pkg::*;

  localparam int W = 4;

  logic [3:0]   opcode;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] y;
  logic         cout, overflow, negative, zero;
  logic [3:0]   flags_q;
  logic         clk, rst;

  int n_checks = 0;
  int n_pass   = 0;

  alu #(.WIDTH(W)) dut (
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .y        (y),
    .cout     (cout),
    .overflow (overflow),
    .negative (negative),
    .zero     (zero),
    .flags_q  (flags_q),
    .clk      (clk),
    .rst      (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result bundle layout: {y[3:0], cout, overflow, negative, zero}
  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Reference model written from the arithmetic rules, not the hardware structure.
  function automatic logic [7:0] model(input logic [3:0] op, input int ai, input int bi, input int ci);
    int  mask = (1 << W) - 1;
    int  half = 1 << (W - 1);
    int  sa   = (ai >= half) ? ai - (1 << W) : ai;
    int  sb   = (bi >= half) ? bi - (1 << W) : bi;
    int  yv = 0, cv = 0, s = 0, ss = 0, r;
    bit  vv = 0, arith = 0;
    logic [3:0] yl;
    case (op)
      LSL: if (bi == 0) yv = ai;
           else if (bi < W) begin s = ai << bi; yv = s & mask; cv = (s >> W) & 1; end
      LSR: if (bi == 0) yv = ai;
           else if (bi < W) begin yv = ai >> bi; cv = (ai >> (bi - 1)) & 1; end
      ASR: if (bi == 0) yv = ai;
           else if (bi < W) begin yv = (sa >>> bi) & mask; cv = (ai >> (bi - 1)) & 1; end
           else begin yv = (sa < 0) ? mask : 0; cv = (sa < 0) ? 1 : 0; end
      ROL: begin r = bi % W; yv = ((ai << r) | (ai >> (W - r))) & mask; cv = yv & 1; end
      NOT:  yv = ~ai & mask;
      AND:  yv = ai & bi;
      OR:   yv = ai | bi;
      XOR:  yv = ai ^ bi;
      NAND: yv = ~(ai & bi) & mask;
      NOR:  yv = ~(ai | bi) & mask;
      XNOR: yv = ~(ai ^ bi) & mask;
      ADD: begin arith = 1; s = ai + bi + ci;                ss = sa + sb + ci;     end
      SUB: begin arith = 1; s = ai + (~bi & mask) + 1;       ss = sa - sb;          end
      SBC: begin arith = 1; s = ai + (~bi & mask) + ci;      ss = sa - sb - 1 + ci; end
      INC: begin arith = 1; s = ai + 1;                      ss = sa + 1;           end
      DEC: begin arith = 1; s = ai + mask;                   ss = sa - 1;           end
      default: ;
    endcase
    if (arith) begin
      yv = s & mask;
      cv = (s >> W) & 1;
      vv = (ss < -half) || (ss > half - 1);
    end
    yl = yv[3:0];
    return {yl, cv[0], vv, yl[3], (yl == 4'd0)};
  endfunction

  function automatic logic [3:0] flags_of(input logic [7:0] m);
    return {m[1], m[0], m[3], m[2]};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [3:0] av, input logic [3:0] bv, input logic cv);
    opcode = op; a = av; b = bv; cin = cv;
  endtask

  vec_t       vecs[$];
  logic [7:0] m;

  initial begin
    // Directed vectors: {op, a, b, cin, {y, cout, ovf, neg, zero}}
    vecs.push_back('{LSL,  4'b0001, 4'd1, 1'b0, {4'b0010, 4'b0000}});
    vecs.push_back('{LSR,  4'b0001, 4'd1, 1'b0, {4'b0000, 4'b1001}});
    vecs.push_back('{ASR,  4'b0001, 4'd1, 1'b0, {4'b0000, 4'b1001}});
    vecs.push_back('{ASR,  4'b1001, 4'd1, 1'b0, {4'b1100, 4'b1010}});
    vecs.push_back('{NOT,  4'b1000, 4'd0, 1'b0, {4'b0111, 4'b0000}});
    vecs.push_back('{AND,  4'b1111, 4'b0111, 1'b0, {4'b0111, 4'b0000}});
    vecs.push_back('{OR,   4'b1010, 4'b0101, 1'b0, {4'b1111, 4'b0010}});
    vecs.push_back('{XOR,  4'b1100, 4'b1010, 1'b0, {4'b0110, 4'b0000}});
    vecs.push_back('{ADD,  4'b0111, 4'b0001, 1'b0, {4'b1000, 4'b0110}});
    vecs.push_back('{SUB,  4'b0000, 4'b0001, 1'b0, {4'b1111, 4'b0010}});
    vecs.push_back('{LSL,  4'b1000, 4'd0, 1'b0, {4'b1000, 4'b0010}});
    vecs.push_back('{LSL,  4'b1001, 4'd4, 1'b0, {4'b0000, 4'b0001}});
    vecs.push_back('{LSL,  4'b0110, 4'd3, 1'b0, {4'b0000, 4'b1001}});
    vecs.push_back('{LSR,  4'b1001, 4'd7, 1'b0, {4'b0000, 4'b0001}});
    vecs.push_back('{ASR,  4'b1001, 4'd5, 1'b0, {4'b1111, 4'b1010}});
    vecs.push_back('{ROL,  4'b1001, 4'd1, 1'b0, {4'b0011, 4'b1000}});
    vecs.push_back('{ROL,  4'b1001, 4'd5, 1'b0, {4'b0011, 4'b1000}});
    vecs.push_back('{INC,  4'b0111, 4'd0, 1'b0, {4'b1000, 4'b0110}});
    vecs.push_back('{DEC,  4'b1000, 4'd0, 1'b0, {4'b0111, 4'b1100}});
    vecs.push_back('{SBC,  4'b0101, 4'b0011, 1'b0, {4'b0001, 4'b1000}});
    vecs.push_back('{NAND, 4'b1100, 4'b1010, 1'b0, {4'b0111, 4'b0000}});
    vecs.push_back('{NOR,  4'b1100, 4'b1010, 1'b0, {4'b0001, 4'b0000}});
    vecs.push_back('{XNOR, 4'b1100, 4'b1010, 1'b0, {4'b1001, 4'b0010}});
    vecs.push_back('{ADD,  4'b1111, 4'b0001, 1'b1, {4'b0001, 4'b1000}});

    // Reset state; combinational path must ignore rst.
    rst = 1'b1;
    drive(ADD, 4'b1111, 4'b0001, 1'b0);
    #2;
    check("reset_flags_q", flags_q, 4'b0000);
    check("comb_during_reset", {y, cout, overflow, negative, zero}, {4'b0000, 4'b1001});

    // First capture after reset release: ADD 1111+0001 -> {n,z,c,v} = 0110.
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("flags_after_release", flags_q, 4'b0110);

    // Directed table, combinational only.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      #1;
      check($sformatf("vec%0d_op%0d", i, vecs[i].op), {y, cout, overflow, negative, zero}, vecs[i].exp);
    end

    // Randomized against the model, including registered flags.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      #1;
      m = model(opcode, int'(a), int'(b), int'(cin));
      check($sformatf("rand%0d_op%0d_a%0d_b%0d_c%0d", i, opcode, a, b, cin),
            {y, cout, overflow, negative, zero}, m);
      @(posedge clk); #1;
      check($sformatf("rand%0d_flags_q", i), flags_q, flags_of(m));
    end

    // Mid-run asynchronous reset.
    @(negedge clk);
    drive(OR, 4'b1010, 4'b0101, 1'b0);
    @(posedge clk); #1;
    check("flags_before_reset", flags_q, 4'b1000);
    #2 rst = 1'b1;
    #1;
    check("flags_async_clear", flags_q, 4'b0000);
    @(posedge clk); #1;
    check("flags_held_in_reset", flags_q, 4'b0000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("flags_after_second_release", flags_q, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The parameter SHALL be WIDTH, default 4, the data width of a, b and y (minimum 2).
REQ-002 Port declaration order SHALL be opcode, a, b, cin, y, cout, overflow, negative, zero, flags_q, clk, rst, so positional hookup of the first nine ports is valid; clk and rst are listed first below.
REQ-003 clk  input  1  the single clock; drives only the status register.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  4  operation select.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B; unsigned shift amount for shift and rotate ops.
REQ-008 cin  input  1  carry in for ADD and SBC.
REQ-009 y  output  WIDTH  result.
REQ-010 cout  output  1  carry out, or last bit shifted out.
REQ-011 overflow  output  1  signed two's-complement overflow.
REQ-012 negative  output  1  y[WIDTH-1].
REQ-013 zero  output  1  high when y equals 0.
REQ-014 flags_q  output  4  registered {negative, zero, cout, overflow}.

Function
REQ-015 y, cout, overflow, negative and zero SHALL be purely combinational from opcode, a, b and cin, with zero latency and no dependence on clk.
REQ-016 Opcode map SHALL be:
- 0000 LSL: a << b
- 0001 LSR: a >> b, zero fill
- 0010 ASR: a >>> b, sign fill
- 0011 NOT: ~a
- 0100 AND: a & b
- 0101 OR: a | b
- 0110 XOR: a ^ b
- 0111 ADD: a + b + cin
- 1000 SUB: a + ~b + 1
- 1001 SBC: a + ~b + cin
- 1010 INC: a + 1
- 1011 DEC: a + all-ones
- 1100 NAND
- 1101 NOR
- 1110 XNOR
- 1111 ROL: a rotated left by b mod WIDTH
REQ-017 Arithmetic SHALL be computed at WIDTH+1 bits; cout is bit WIDTH of the sum. For SUB/SBC, cout=1 means no borrow.
REQ-018 overflow SHALL be set for ADD, SUB, SBC, INC and DEC when both effective operands share a sign that differs from y's sign; it is 0 for all other ops.
REQ-019 Shifts with b=0 SHALL give y=a and cout=0.
REQ-020 Shifts with 0<b<WIDTH SHALL set cout to the last bit shifted out.
REQ-021 Shifts with b>=WIDTH SHALL give:
- LSL, LSR: y=0, cout=0
- ASR: y = all bits equal to a[WIDTH-1], cout=a[WIDTH-1]
REQ-022 ROL SHALL set cout = y[0].
REQ-023 NOT, AND, OR, XOR, NAND, NOR and XNOR SHALL set cout=0.
REQ-024 negative and zero SHALL always be derived from the final y, for every opcode.
REQ-025 flags_q SHALL capture {negative, zero, cout, overflow} on every rising clk edge.

Reset
REQ-026 rst high SHALL clear flags_q to 0 immediately, without waiting for a clock edge; it is held while rst is asserted.
REQ-027 rst SHALL NOT affect the combinational outputs; no other state exists.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode enum (4-bit, names as in REQ-016); no other shared constants.
REQ-029 One sub-module, alu_shifter, SHALL implement LSL, LSR, ASR and ROL with carry-out; all other operations stay inline in alu.

Verification (WIDTH=4, each check made after inputs settle, no clock needed)
REQ-030 LSL a=0001 b=0001 -> y=0010, cout=0. LSR a=0001 b=0001 -> y=0000, zero=1, cout=1.
REQ-031 ASR a=0001 b=0001 -> y=0000. ASR a=1001 b=0001 -> y=1100, negative=1, cout=1.
REQ-032 NOT a=1000 -> y=0111. AND a=1111 b=0111 -> y=0111.
REQ-033 OR a=1010 b=0101 -> y=1111, negative=1. XOR a=1100 b=1010 -> y=0110.
REQ-034 ADD a=0111 b=0001 cin=0 -> y=1000, overflow=1, cout=0. SUB a=0000 b=0001 -> y=1111, cout=0, overflow=0.
REQ-035 Reset with clock: rst=1 mid-run -> flags_q=0000 at once; rst=0 then one clk edge with ADD a=1111 b=0001 -> flags_q=0110.
